// File: rtl/aes_round_ctrl_if.sv
// Control/status bundle between the Avalon register block and the AES inverse-cipher round controller.
// The register side uses modport master; the round controller uses modport slave.
interface aes_round_ctrl_if;
   logic       AES_START;
   logic       AES_DONE;
   logic [3:0] Round;
   logic [1:0] Sel;
   logic       State_Load;
   logic [1:0] Col_Sel;
   logic       Busy;

   modport master (
      output AES_START,
      input  AES_DONE,
      input  Round,
      input  Sel,
      input  State_Load,
      input  Col_Sel,
      input  Busy
   );

   modport slave (
      input  AES_START,
      output AES_DONE,
      output Round,
      output Sel,
      output State_Load,
      output Col_Sel,
      output Busy
   );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128 decryption round sequencer: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns over rounds 10..0.
// Define AES_MIXCOL_SERIAL_EN to process InvMixColumns one column per cycle instead of all four at once.
module aes_round_ctrl (
   input  logic            CLK,
   input  logic            RESET,
   aes_round_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      INIT_ARK,
      ISR,
      ISB,
      ARK,
      IMC,
      DONE
   } state_t;

   state_t     state, state_next;
   logic [3:0] round, round_next;
   logic [1:0] col_cnt, col_next;
   logic [3:0] round_dec;

   // Saturate at zero so a stray IMC exit in round 0 can never wrap the key index.
   assign round_dec = (round != 4'd0) ? round - 4'd1 : 4'd0;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= IDLE;
         round   <= 4'd10;
         col_cnt <= 2'd0;
      end else begin
         state   <= state_next;
         round   <= round_next;
         col_cnt <= col_next;
      end
   end

   always_comb begin
      state_next = state;
      round_next = round;
      col_next   = 2'd0;
      unique case (state)
         IDLE: begin
            round_next = 4'd10;
            if (bus.AES_START) begin
               state_next = INIT_ARK;
            end
         end
         INIT_ARK: begin
            state_next = ISR;
            round_next = 4'd9;
         end
         ISR: begin
            state_next = ISB;
         end
         ISB: begin
            state_next = ARK;
         end
         ARK: begin
            state_next = (round == 4'd0) ? DONE : IMC;
         end
         IMC: begin
`ifdef AES_MIXCOL_SERIAL_EN
            if (col_cnt == 2'd3) begin
               state_next = ISR;
               round_next = round_dec;
            end else begin
               col_next = col_cnt + 2'd1;
            end
`else
            state_next = ISR;
            round_next = round_dec;
`endif
         end
         DONE: begin
            if (!bus.AES_START) begin
               state_next = IDLE;
               round_next = 4'd10;
            end
         end
         default: begin
            state_next = IDLE;
            round_next = 4'd10;
         end
      endcase
   end

   // Every output is a pure decode of registered state, so AES_START never reaches an output combinationally.
   always_comb begin
      bus.Sel        = 2'd0;
      bus.State_Load = 1'b0;
      bus.Busy       = 1'b0;
      bus.AES_DONE   = 1'b0;
      bus.Col_Sel    = 2'd0;
      bus.Round      = round;
      unique case (state)
         IDLE: begin
         end
         INIT_ARK: begin
            bus.State_Load = 1'b1;
            bus.Busy       = 1'b1;
         end
         ISR: begin
            bus.Sel        = 2'd1;
            bus.State_Load = 1'b1;
            bus.Busy       = 1'b1;
         end
         ISB: begin
            bus.Sel        = 2'd2;
            bus.State_Load = 1'b1;
            bus.Busy       = 1'b1;
         end
         ARK: begin
            bus.State_Load = 1'b1;
            bus.Busy       = 1'b1;
         end
         IMC: begin
            bus.Sel        = 2'd3;
            bus.State_Load = 1'b1;
            bus.Busy       = 1'b1;
            bus.Col_Sel    = col_cnt;
         end
         DONE: begin
            bus.AES_DONE = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: full decrypt sequences, DONE hold, start pulse, back-to-back and resets.
// Expected IMC length and latency follow AES_MIXCOL_SERIAL_EN so the bench fits either build.
module tb_aes_round_ctrl;

`ifdef AES_MIXCOL_SERIAL_EN
   localparam int IMC_LEN = 4;
   localparam int LATENCY = 67;
   localparam bit SERIAL  = 1'b1;
`else
   localparam int IMC_LEN = 1;
   localparam int LATENCY = 40;
   localparam bit SERIAL  = 1'b0;
`endif

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   aes_round_ctrl_if bus ();

   aes_round_ctrl dut (
      .CLK   (clk),
      .RESET (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic check_state(input string tag, input int round, input int sel, input int load,
                              input int col, input int busy, input int done);
      check_output({tag, ".Round"},      int'(bus.Round),      round);
      check_output({tag, ".Sel"},        int'(bus.Sel),        sel);
      check_output({tag, ".State_Load"}, int'(bus.State_Load), load);
      check_output({tag, ".Col_Sel"},    int'(bus.Col_Sel),    col);
      check_output({tag, ".Busy"},       int'(bus.Busy),       busy);
      check_output({tag, ".AES_DONE"},   int'(bus.AES_DONE),   done);
   endtask

   task automatic apply_stimulus(input bit rst, input bit start);
      reset         = rst;
      bus.AES_START = start;
   endtask

   // Caller has AES_START=1 set; this walks the whole schedule and leaves the DUT in DONE.
   task automatic run_op(input string tag, input bit pulse);
      int edges;
      edges = 1;
      tick();
      if (pulse) bus.AES_START = 1'b0;
      check_state({tag, " init"}, 10, 0, 1, 0, 1, 0);
      for (int r = 9; r >= 0; r--) begin
         tick(); edges++;
         check_state($sformatf("%s r%0d isr", tag, r), r, 1, 1, 0, 1, 0);
         tick(); edges++;
         check_state($sformatf("%s r%0d isb", tag, r), r, 2, 1, 0, 1, 0);
         tick(); edges++;
         check_state($sformatf("%s r%0d ark", tag, r), r, 0, 1, 0, 1, 0);
         if (r != 0) begin
            for (int c = 0; c < IMC_LEN; c++) begin
               tick(); edges++;
               check_state($sformatf("%s r%0d imc%0d", tag, r, c), r, 3, 1, SERIAL ? c : 0, 1, 0);
            end
         end
      end
      tick(); edges++;
      check_state({tag, " done"}, 0, 0, 0, 0, 0, 1);
      check_output({tag, " latency"}, edges - 1, LATENCY);
   endtask

   initial begin
      checks = 0;
      errors = 0;

      apply_stimulus(1'b1, 1'b0);
      tick();
      tick();
      apply_stimulus(1'b0, 1'b0);
      check_state("reset", 10, 0, 0, 0, 0, 0);
      tick();
      tick();
      check_state("idle hold", 10, 0, 0, 0, 0, 0);

      // Held start, then DONE held 5 cycles before release.
      apply_stimulus(1'b0, 1'b1);
      run_op("op1", 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_state($sformatf("done hold%0d", i), 0, 0, 0, 0, 0, 1);
      end
      apply_stimulus(1'b0, 1'b0);
      tick();
      check_state("release idle", 10, 0, 0, 0, 0, 0);

      // Single-cycle start pulse; DONE must last exactly one cycle.
      apply_stimulus(1'b0, 1'b1);
      run_op("pulse", 1'b1);
      tick();
      check_state("pulse idle", 10, 0, 0, 0, 0, 0);

      // Back-to-back: drop at DONE, re-raise next cycle.
      apply_stimulus(1'b0, 1'b1);
      run_op("b2b_a", 1'b0);
      apply_stimulus(1'b0, 1'b0);
      tick();
      check_state("b2b idle", 10, 0, 0, 0, 0, 0);
      apply_stimulus(1'b0, 1'b1);
      run_op("b2b_b", 1'b0);

      // Reset while in DONE with start still high.
      apply_stimulus(1'b1, 1'b1);
      tick();
      check_state("rst in done", 10, 0, 0, 0, 0, 0);
      apply_stimulus(1'b0, 1'b0);
      tick();
      check_state("idle after done rst", 10, 0, 0, 0, 0, 0);

      // Reset in round 5 IMC, start kept high so it must win priority.
      apply_stimulus(1'b0, 1'b1);
      for (int i = 0; i < 2 + 4 * (3 + IMC_LEN) + 3; i++) tick();
      check_state("r5 imc", 5, 3, 1, 0, 1, 0);
      apply_stimulus(1'b1, 1'b1);
      tick();
      check_state("rst mid op", 10, 0, 0, 0, 0, 0);
      apply_stimulus(1'b0, 1'b1);
      run_op("after rst", 1'b0);
      apply_stimulus(1'b0, 1'b0);
      tick();
      check_state("final idle", 10, 0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
